display_scanner: RTL

- Downstream consumer of the 3-phase one-hot ring counter.
- Turns each phase into a digit strobe for a multiplexed common-anode 7-segment display.
- Double-buffers digit data behind a load handshake, inserts an anti-ghosting blank gap on every phase change, and flags phase vectors that are not one-hot.
- Sits between the ring counter and the board display pins.

---
 rtl/display_pkg.sv | 34 +++
 rtl/hex_to_seg.sv | 14 +
 rtl/display_scanner.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared state type and segment constants for the display scanner.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.

package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Entry n sits at HEX_SEG[n]; the concatenation therefore lists F down to 0.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/hex_to_seg.sv
// rtl/hex_to_seg.sv - combinational hex nibble to active-low 7-segment decoder.

module hex_to_seg
    import display_pkg::*;
#(
    parameter int DIGIT_W = 4
) (
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [6:0]         o_seg
);

    assign o_seg = HEX_SEG[i_digit];

endmodule

// File: rtl/display_scanner.sv
// rtl/display_scanner.sv - multiplexed 7-segment scanner driven by a one-hot phase ring.
// Define DISPLAY_SCANNER_LZB_EN to blank leading zero digits.

module display_scanner
    import display_pkg::*;
#(
    parameter int DIGITS       = 3,
    parameter int DIGIT_W      = 4,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [DIGITS-1:0]         phase,
    input  logic                      phase_valid,
    input  logic                      load,
    input  logic [DIGITS*DIGIT_W-1:0] load_data,
    output logic                      load_ready,
    input  logic                      clear_err,
    output logic [DIGITS-1:0]         anode,
    output logic [6:0]                segments,
    output logic                      phase_err
);

    localparam logic [7:0] LP_BLANK_LAST = 8'(BLANK_CYCLES - 1);

    state_t                    r_state;
    logic [7:0]                r_cnt;
    logic [DIGITS-1:0]         r_phase_q;
    logic [DIGITS*DIGIT_W-1:0] r_active;
    logic [DIGITS*DIGIT_W-1:0] r_shadow;
    logic                      r_pending;
    logic                      r_phase_err;
    logic [DIGITS-1:0]         r_anode;
    logic [6:0]                r_segments;

    logic                      w_onehot;
    logic                      w_phase_ok;
    logic                      w_phase_bad;
    logic                      w_frame;
    logic                      w_load_acc;
    logic                      w_show;
    logic [DIGIT_W-1:0]        w_digit;
    logic [6:0]                w_dec_seg;
    logic [6:0]                w_show_seg;

    assign w_onehot    = (phase != '0) && ((phase & (phase - DIGITS'(1))) == '0);
    assign w_phase_ok  = phase_valid && w_onehot;
    assign w_phase_bad = phase_valid && !w_onehot;
    assign w_frame     = w_phase_ok && phase[0];
    assign w_load_acc  = load && !r_pending;
    // A new phase_valid blanks immediately so the old digit never ghosts into the new slot.
    assign w_show      = (r_state == SHOW) && !phase_valid;

    always_comb begin
        w_digit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_phase_q[i]) begin
                w_digit = w_digit | r_active[i*DIGIT_W +: DIGIT_W];
            end
        end
    end

    hex_to_seg #(
        .DIGIT_W (DIGIT_W)
    ) u_hex_to_seg (
        .i_digit (w_digit),
        .o_seg   (w_dec_seg)
    );

`ifdef DISPLAY_SCANNER_LZB_EN
    logic [DIGITS-1:1] w_zero_from;

    for (genvar g = 1; g < DIGITS; g++) begin : g_lzb
        assign w_zero_from[g] = (r_active[DIGITS*DIGIT_W-1 : g*DIGIT_W] == '0);
    end

    assign w_show_seg = (|(r_phase_q[DIGITS-1:1] & w_zero_from)) ? SEG_BLANK : w_dec_seg;
`else
    assign w_show_seg = w_dec_seg;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_phase_q   <= '0;
            r_active    <= '0;
            r_shadow    <= '0;
            r_pending   <= 1'b0;
            r_phase_err <= 1'b0;
            r_anode     <= '1;
            r_segments  <= SEG_BLANK;
        end else begin
            // Frame boundary copies the old shadow; a same-cycle load refills it and stays pending.
            if (w_frame) begin
                r_active <= r_shadow;
            end
            if (w_load_acc) begin
                r_shadow  <= load_data;
                r_pending <= 1'b1;
            end else if (w_frame) begin
                r_pending <= 1'b0;
            end

            if (w_phase_bad) begin
                r_phase_err <= 1'b1;
            end else if (clear_err) begin
                r_phase_err <= 1'b0;
            end

            if (w_phase_bad) begin
                r_state <= IDLE;
            end else if (w_phase_ok) begin
                r_phase_q <= phase;
                r_cnt     <= '0;
                r_state   <= BLANK;
            end else begin
                case (r_state)
                    BLANK: begin
                        if (r_cnt == LP_BLANK_LAST) begin
                            r_state <= SHOW;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end

            if (w_show) begin
                r_anode    <= ~r_phase_q;
                r_segments <= w_show_seg;
            end else begin
                r_anode    <= '1;
                r_segments <= SEG_BLANK;
            end
        end
    end

    assign load_ready = ~r_pending;
    assign anode      = r_anode;
    assign segments   = r_segments;
    assign phase_err  = r_phase_err;

endmodule
